// File: rtl/beat_pattern_gen_if.sv
// Output handshake bundle for beat_pattern_gen: valid/ready beat stream plus wrap marker.
// The loop_cnt member exists only when LOOP_CNT_EN is defined.
interface beat_pattern_gen_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) ();
    logic              data_ready;
    logic              data_valid;
    logic [DATA_W-1:0] data;
    logic              wrap;
`ifdef LOOP_CNT_EN
    logic [CNT_W-1:0]  loop_cnt;
`endif

    modport master (
        input  data_ready,
        output data_valid,
        output data,
        output wrap
`ifdef LOOP_CNT_EN
        , output loop_cnt
`endif
    );

    modport slave (
        output data_ready,
        input  data_valid,
        input  data,
        input  wrap
`ifdef LOOP_CNT_EN
        , input loop_cnt
`endif
    );
endinterface

// File: rtl/beat_pattern_gen.sv
// Beatmap note-value generator: up-wrap, down-wrap, ping-pong or constant sweep over
// START..STOP in STEP increments, advancing on valid/ready. Optional feature: LOOP_CNT_EN.
module beat_pattern_gen #(
    parameter int DATA_W = 8,
    parameter int START  = 80,
    parameter int STOP   = 96,
    parameter int STEP   = 4,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic [1:0]           mode,
    beat_pattern_gen_if.master   bus
);
    // One guard bit against overflow plus a sign bit so START-STEP can go negative.
    localparam int AW = DATA_W + 2;

    localparam logic [DATA_W-1:0]    START_D = DATA_W'(START);
    localparam logic [DATA_W-1:0]    STOP_D  = DATA_W'(STOP);
    localparam logic signed [AW-1:0] START_S = AW'(START);
    localparam logic signed [AW-1:0] STOP_S  = AW'(STOP);
    localparam logic signed [AW-1:0] STEP_S  = AW'(STEP);

    localparam logic [1:0] MODE_UP    = 2'd0;
    localparam logic [1:0] MODE_DOWN  = 2'd1;
    localparam logic [1:0] MODE_PING  = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    typedef enum logic [1:0] {IDLE, UP, DOWN, HOLD} state_t;

    function automatic logic signed [AW-1:0] widen(input logic [DATA_W-1:0] v);
        return $signed({2'b00, v});
    endfunction

    function automatic logic [DATA_W-1:0] narrow(input logic signed [AW-1:0] v);
        return v[DATA_W-1:0];
    endfunction

    // Ping-pong turnaround at the bottom: step up, but never past STOP.
    function automatic logic [DATA_W-1:0] sat_up(input logic [DATA_W-1:0] cur,
                                                 input logic signed [AW-1:0] nxt);
        return (nxt > STOP_S) ? cur : narrow(nxt);
    endfunction

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                wrap_q, wrap_d;
    logic [1:0]          mode_q, mode_d;
    logic signed [AW-1:0] up_s, dn_s;
    logic                hs;
`ifdef LOOP_CNT_EN
    logic [CNT_W-1:0]    loop_cnt_q, loop_cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        mode_d  = mode_q;
        up_s    = widen(data_q) + STEP_S;
        dn_s    = widen(data_q) - STEP_S;
        hs      = valid_q && bus.data_ready;

        if (state_q == IDLE) begin
            if (enable) begin
                valid_d = 1'b1;
                mode_d  = mode;
                case (mode)
                    MODE_DOWN:  begin data_d = STOP_D;  state_d = DOWN; end
                    MODE_CONST: begin data_d = START_D; state_d = HOLD; end
                    default:    begin data_d = START_D; state_d = UP;   end
                endcase
            end
        end else if (hs) begin
            if (!enable) begin
                state_d = IDLE;
                valid_d = 1'b0;
                data_d  = START_D;
            end else begin
                case (state_q)
                    UP: begin
                        if (up_s <= STOP_S) begin
                            data_d = narrow(up_s);
                        end else if (mode_q != MODE_PING) begin
                            data_d = START_D;
                            wrap_d = 1'b1;
                        end else if (dn_s >= START_S) begin
                            data_d  = narrow(dn_s);
                            state_d = DOWN;
                            wrap_d  = (dn_s == START_S);
                        end else begin
                            wrap_d = 1'b1;
                        end
                    end
                    DOWN: begin
                        // In ping-pong a period starts when the sweep lands back on START.
                        if (dn_s >= START_S) begin
                            data_d = narrow(dn_s);
                            wrap_d = (mode_q == MODE_PING) && (dn_s == START_S);
                        end else if (mode_q != MODE_PING) begin
                            data_d = STOP_D;
                            wrap_d = 1'b1;
                        end else begin
                            data_d  = sat_up(data_q, up_s);
                            state_d = UP;
                            wrap_d  = (up_s > STOP_S);
                        end
                    end
                    default: wrap_d = 1'b1;
                endcase
            end
        end

`ifdef LOOP_CNT_EN
        loop_cnt_d = loop_cnt_q + CNT_W'(wrap_d);
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            data_q     <= START_D;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
            mode_q     <= MODE_UP;
`ifdef LOOP_CNT_EN
            loop_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            wrap_q     <= wrap_d;
            mode_q     <= mode_d;
`ifdef LOOP_CNT_EN
            loop_cnt_q <= loop_cnt_d;
`endif
        end
    end

    assign bus.data_valid = valid_q;
    assign bus.data       = data_q;
    assign bus.wrap       = wrap_q;
`ifdef LOOP_CNT_EN
    assign bus.loop_cnt   = loop_cnt_q;
`endif

endmodule

// File: tb/tb_beat_pattern_gen.sv
// Scoreboard bench for beat_pattern_gen: stimulus queues expected beats, a monitor
// compares every newly presented beat; direct checks cover idle, hold and reset.
module tb_beat_pattern_gen;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode_i = 2'd0;
    logic       ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int seen   = 0;

    typedef struct {
        logic [7:0] d;
        logic       w;
    } beat_t;
    beat_t exp_q[$];

    beat_pattern_gen_if #(.DATA_W(8), .CNT_W(8)) bus ();
    assign bus.data_ready = ready;

    beat_pattern_gen #(
        .DATA_W(8), .START(80), .STOP(96), .STEP(4), .CNT_W(8)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .enable(enable),
        .mode(mode_i),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic w);
        beat_t b;
        b.d = d;
        b.w = w;
        exp_q.push_back(b);
    endtask

    // Monitor: ready only changes just after a falling edge, so the value seen here
    // is the one the DUT saw at the preceding rising edge.
    initial begin
        logic       prev_valid;
        logic [7:0] held;
        beat_t      e;
        prev_valid = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (resetn && bus.data_valid && (!prev_valid || ready)) begin
                seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data=%0d wrap=%0d expected none", bus.data, bus.wrap);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("beat%0d_data", seen), 32'(bus.data), 32'(e.d));
                    chk($sformatf("beat%0d_wrap", seen), 32'(bus.wrap), 32'(e.w));
                end
                held = bus.data;
            end else if (resetn && bus.data_valid) begin
                chk("stall_data_stable", 32'(bus.data), 32'(held));
                chk("stall_wrap_clear", 32'(bus.wrap), 32'd0);
            end
            prev_valid = resetn && bus.data_valid;
        end
    end

    task automatic wait_seen(input int target);
        int cyc = 0;
        while (seen < target && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("beats_arrived", 32'(seen >= target), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(bus.data_valid), 32'd0);
        chk({tag, "_data"},  32'(bus.data), 32'd80);
        chk({tag, "_wrap"},  32'(bus.wrap), 32'd0);
    endtask

    // Run n beats at full rate in mode m; mode switches to alt after the first beat.
    task automatic run(input logic [1:0] m, input int n, input logic [1:0] alt);
        int t0 = seen;
        mode_i = m;
        enable = 1'b1;
        ready  = 1'b1;
        wait_seen(t0 + 1);
        mode_i = alt;
        wait_seen(t0 + n);
        enable = 1'b0;
        @(negedge clk); #1;
        check_idle("after_run");
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        #1;
        check_idle("in_reset");
        resetn = 1'b1;
        @(negedge clk); #1;
        check_idle("post_reset");
`ifdef LOOP_CNT_EN
        chk("reset_loop_cnt", 32'(bus.loop_cnt), 32'd0);
`endif

        // Up-wrap: wrap only with the second 80
        push(80,0); push(84,0); push(88,0); push(92,0); push(96,0); push(80,1);
        run(2'd0, 6, 2'd0);

        // Ping-pong: period of 8, wrap on the returning 80
        push(80,0); push(84,0); push(88,0); push(92,0); push(96,0);
        push(92,0); push(88,0); push(84,0); push(80,1); push(84,0);
        run(2'd2, 10, 2'd2);

        // Down-wrap, mid-run switch to mode 0 must be ignored
        push(96,0); push(92,0); push(88,0); push(84,0); push(80,0); push(96,1); push(92,0);
        run(2'd1, 7, 2'd0);

        // Constant START: every accepted beat pulses wrap
        push(80,0); push(80,1); push(80,1);
        run(2'd3, 3, 2'd3);

        // Backpressure at 88 for 5 cycles
        push(80,0); push(84,0); push(88,0); push(92,0); push(96,0);
        t0 = seen;
        mode_i = 2'd0; enable = 1'b1; ready = 1'b1;
        wait_seen(t0 + 3);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("bp_data", 32'(bus.data), 32'd88);
            chk("bp_valid", 32'(bus.data_valid), 32'd1);
        end
        ready = 1'b1;
        wait_seen(t0 + 5);
        enable = 1'b0;
        @(negedge clk); #1;
        check_idle("bp_end");

        // enable=0 while stalled: valid holds until the handshake
        push(80,0); push(84,0);
        t0 = seen;
        mode_i = 2'd0; enable = 1'b1; ready = 1'b1;
        wait_seen(t0 + 2);
        ready = 1'b0; enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("dis_hold_valid", 32'(bus.data_valid), 32'd1);
            chk("dis_hold_data", 32'(bus.data), 32'd84);
        end
        ready = 1'b1;
        @(negedge clk); #1;
        check_idle("dis_done");
        push(80,0);
        run(2'd0, 1, 2'd0);

        // Three full periods from a clean reset, then an asynchronous reset mid-run
        resetn = 1'b0;
        @(negedge clk); #1;
        resetn = 1'b1;
        for (int p = 0; p < 3; p++) begin
            push(80, p > 0); push(84,0); push(88,0); push(92,0); push(96,0);
        end
        push(80,1);
        run(2'd0, 16, 2'd0);
`ifdef LOOP_CNT_EN
        chk("loop_cnt_3", 32'(bus.loop_cnt), 32'd3);
`endif
        push(80,0); push(84,0);
        t0 = seen;
        mode_i = 2'd2; enable = 1'b1; ready = 1'b1;
        wait_seen(t0 + 2);
        resetn = 1'b0;
        enable = 1'b0;
        #1;
        check_idle("async_reset");
`ifdef LOOP_CNT_EN
        chk("async_reset_loop_cnt", 32'(bus.loop_cnt), 32'd0);
`endif
        @(negedge clk); #1;
        resetn = 1'b1;
        @(negedge clk); #1;
        check_idle("after_async_reset");

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
